alu_serial_rx: RTL and testbench

Serial-input front end of the ALU: deserializes the 11-bit packet stream on `sin`, assembles a full request (B, A, op), checks the 4-bit CRC and the frame structure, and presents one decoded request or error per frame on a valid/ready interface to the ALU execute stage. The ALU sits directly downstream, and the stimulus BFM's `send_op` drives `sin`.

---
 rtl/alu_serial_rx.sv | 158 +++++++++++++++
 tb/tb_alu_serial_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_rx.sv
// Serial front end of the ALU: deserializes 11-bit packets into {B, A, op},
// validates framing and CRC4, and presents one result per frame on valid/ready.
module alu_serial_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  op,
    output logic [2:0]  err_flags,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TYPE    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_STOP    = 2'd3
    } state_t;

    state_t      state_r;
    logic        type_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  payload_r;
    logic [63:0] shreg_r;
    logic [3:0]  pkt_cnt_r;
    logic [3:0]  crc_r;
    logic        corrupt_r;

    logic        frame_done_s;
    logic        slot_free_s;
    logic        corrupt_now_s;
    logic [2:0]  rx_op_s;
    logic [3:0]  rx_crc_s;
    logic [3:0]  calc_crc_s;
    logic [2:0]  flags_s;

    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
        logic fb;
        fb = crc[3] ^ d;
        crc4_step = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic op_supported(input logic [2:0] code);
        case (code)
            3'b000, 3'b001, 3'b100, 3'b101: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    endfunction

    // Frame completion decode: finish the CRC over {1, op} and rank the error flags
    always_comb begin
        rx_op_s       = payload_r[6:4];
        rx_crc_s      = payload_r[3:0];
        corrupt_now_s = corrupt_r | ~sin;
        slot_free_s   = ~out_valid | out_ready;
        calc_crc_s    = crc4_step(crc4_step(crc4_step(crc4_step(crc_r, 1'b1),
                            rx_op_s[2]), rx_op_s[1]), rx_op_s[0]);
        if ((state_r == ST_STOP) && type_r) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
        if ((pkt_cnt_r != 4'd8) || corrupt_now_s) begin
            flags_s = 3'b100;
        end else if (calc_crc_s != rx_crc_s) begin
            flags_s = 3'b010;
        end else if (!op_supported(rx_op_s)) begin
            flags_s = 3'b001;
        end else begin
            flags_s = 3'b000;
        end
    end

    // Packet FSM and frame accumulation (shift register, packet count, CRC, corrupt flag)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            type_r    <= 1'b0;
            bit_cnt_r <= 3'd0;
            payload_r <= 8'd0;
            shreg_r   <= 64'd0;
            pkt_cnt_r <= 4'd0;
            crc_r     <= 4'd0;
            corrupt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!sin) begin
                        state_r <= ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    type_r    <= sin;
                    bit_cnt_r <= 3'd0;
                    state_r   <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    payload_r <= {payload_r[6:0], sin};
                    if (!type_r) begin
                        shreg_r <= {shreg_r[62:0], sin};
                        crc_r   <= crc4_step(crc_r, sin);
                    end
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    state_r <= ST_IDLE;
                    if (type_r) begin
                        pkt_cnt_r <= 4'd0;
                        crc_r     <= 4'd0;
                        corrupt_r <= 1'b0;
                    end else begin
                        if (pkt_cnt_r != 4'd9) begin
                            pkt_cnt_r <= pkt_cnt_r + 4'd1;
                        end
                        if (!sin) begin
                            corrupt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output slot: load on completion when free, release on handshake, flag drops
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a         <= 32'd0;
            b         <= 32'd0;
            op        <= 3'd0;
            err_flags <= 3'd0;
            overrun   <= 1'b0;
        end else begin
            if (frame_done_s && slot_free_s) begin
                out_valid <= 1'b1;
                b         <= shreg_r[63:32];
                a         <= shreg_r[31:0];
                op        <= rx_op_s;
                err_flags <= flags_s;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (frame_done_s && !slot_free_s) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: directed vector table, randomized frames
// against a polynomial-division CRC model, and handshake/overrun/reset sequences.
module tb_alu_serial_rx;

    logic        clk;
    logic        rst;
    logic        sin;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  err_flags;
    logic        overrun;

    int n_total;
    int n_pass;
    int hs_count;

    alu_serial_rx dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .err_flags (err_flags),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted results (state seen just before the edge)
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_count <= hs_count + 1;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  ctl;
        logic        use_model;
        logic [2:0]  mop;
        int          ndata;
        int          bad_pkt;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[11];

    // CRC as the remainder of {B, A, 1, op} * x^4 divided by x^4+x+1
    function automatic logic [3:0] model_crc(input logic [31:0] a_v, input logic [31:0] b_v,
                                             input logic [2:0] op_v);
        logic [71:0] rem;
        rem = {b_v, a_v, 1'b1, op_v, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (rem[i]) rem[i -: 5] = rem[i -: 5] ^ 5'b10011;
        end
        return rem[3:0];
    endfunction

    function automatic logic [2:0] model_flags(input int ndata, input logic bad_stop,
                                               input logic [7:0] ctl, input logic [31:0] a_v,
                                               input logic [31:0] b_v);
        logic [2:0] op_v;
        op_v = ctl[6:4];
        if (ndata != 8 || bad_stop) return 3'b100;
        if (model_crc(a_v, b_v, op_v) != ctl[3:0]) return 3'b010;
        if (!(op_v inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
        return 3'b000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        sin = v;
    endtask

    task automatic send_packet(input logic typ, input logic [7:0] data, input logic stop_v);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(stop_v);
    endtask

    // Sends ndata data packets then the ctl packet; returns at the negedge after the ctl stop edge
    task automatic send_frame(input logic [31:0] a_v, input logic [31:0] b_v, input logic [7:0] ctl,
                              input int ndata, input int bad_pkt, input logic ready_at_stop,
                              output logic pre_valid);
        logic [63:0] ba;
        int offs;
        ba = {b_v, a_v};
        offs = (ndata > 8) ? ndata - 8 : 0;
        for (int p = 0; p < ndata; p++) begin
            if (p < offs) send_packet(1'b0, 8'hA5, (bad_pkt == p) ? 1'b0 : 1'b1);
            else send_packet(1'b0, ba[63 - 8 * (p - offs) -: 8], (bad_pkt == p) ? 1'b0 : 1'b1);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(ctl[i]);
        @(negedge clk);
        pre_valid = out_valid;
        if (ready_at_stop) out_ready = 1'b1;
        sin = (bad_pkt == ndata) ? 1'b0 : 1'b1;
        @(negedge clk);
        sin = 1'b1;
    endtask

    initial begin
        logic        pv;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        logic [3:0]  rcrc;
        logic [7:0]  ctl;
        int          bad;
        int          hs0;

        n_total   = 0;
        n_pass    = 0;
        hs_count  = 0;
        sin       = 1'b1;
        out_ready = 1'b1;
        rst       = 1'b1;

        vecs[0]  = '{32'h0, 32'h0, 8'h0B, 1'b0, 3'b000, 8, -1, 3'b000};
        vecs[1]  = '{32'h0, 32'h0, 8'h0A, 1'b0, 3'b000, 8, -1, 3'b010};
        vecs[2]  = '{32'h0, 32'h0, 8'h2D, 1'b0, 3'b000, 8, -1, 3'b001};
        vecs[3]  = '{32'h0, 32'h0, 8'h0B, 1'b0, 3'b000, 7, -1, 3'b100};
        vecs[4]  = '{32'h0, 32'h0, 8'h0B, 1'b0, 3'b000, 8, -1, 3'b000};
        vecs[5]  = '{32'h0F0F_0F0F, 32'hCAFE_F00D, 8'h00, 1'b1, 3'b101, 8, -1, 3'b000};
        vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 8'h00, 1'b1, 3'b100, 9, -1, 3'b100};
        vecs[7]  = '{32'h0, 32'h0, 8'h0B, 1'b0, 3'b000, 8, 3, 3'b100};
        vecs[8]  = '{32'h0, 32'h0, 8'h0B, 1'b0, 3'b000, 8, 8, 3'b100};
        vecs[9]  = '{32'hFFFF_0000, 32'h0000_FFFF, 8'h00, 1'b1, 3'b011, 8, -1, 3'b001};
        vecs[10] = '{32'h8000_0001, 32'h7FFF_FFFE, 8'h00, 1'b1, 3'b001, 8, -1, 3'b000};

        repeat (2) @(negedge clk);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset a", {32'd0, a}, 64'd0);
        check("reset b", {32'd0, b}, 64'd0);
        check("reset op_flags", {58'd0, op, err_flags}, 64'd0);
        check("reset overrun", {63'd0, overrun}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            ctl = vecs[v].use_model ?
                  {1'b0, vecs[v].mop, model_crc(vecs[v].a, vecs[v].b, vecs[v].mop)} : vecs[v].ctl;
            send_frame(vecs[v].a, vecs[v].b, ctl, vecs[v].ndata, vecs[v].bad_pkt, 1'b0, pv);
            check($sformatf("vec%0d pre_valid", v), {63'd0, pv}, 64'd0);
            check($sformatf("vec%0d out_valid", v), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d err_flags", v), {61'd0, err_flags}, {61'd0, vecs[v].exp_flags});
            check($sformatf("vec%0d op", v), {61'd0, op}, {61'd0, ctl[6:4]});
            if (vecs[v].ndata >= 8) begin
                check($sformatf("vec%0d a", v), {32'd0, a}, {32'd0, vecs[v].a});
                check($sformatf("vec%0d b", v), {32'd0, b}, {32'd0, vecs[v].b});
            end
            repeat (2) @(negedge clk);
        end

        for (int r = 0; r < 24; r++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 3'($urandom_range(0, 7));
            rcrc = model_crc(ra, rb, rop);
            if ($urandom_range(0, 3) == 0) rcrc = rcrc ^ 4'($urandom_range(1, 15));
            bad  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
            ctl  = {1'b0, rop, rcrc};
            send_frame(ra, rb, ctl, 8, bad, 1'b0, pv);
            check($sformatf("rand%0d out_valid", r), {63'd0, out_valid}, 64'd1);
            check($sformatf("rand%0d err_flags", r), {61'd0, err_flags},
                  {61'd0, model_flags(8, bad >= 0, ctl, ra, rb)});
            check($sformatf("rand%0d ab", r), {b, a}, {rb, ra});
            check($sformatf("rand%0d op", r), {61'd0, op}, {61'd0, rop});
            @(negedge clk);
        end

        // Handshake in the same cycle as completion frees the slot
        out_ready = 1'b0;
        send_frame(32'd11, 32'd22, {1'b0, 3'b000, model_crc(32'd11, 32'd22, 3'b000)}, 8, -1, 1'b0, pv);
        check("sameclk first valid", {63'd0, out_valid}, 64'd1);
        send_frame(32'd33, 32'd44, {1'b0, 3'b100, model_crc(32'd33, 32'd44, 3'b100)}, 8, -1, 1'b1, pv);
        check("sameclk second loaded", {b, a}, {32'd44, 32'd33});
        check("sameclk valid", {63'd0, out_valid}, 64'd1);
        check("sameclk no overrun", {63'd0, overrun}, 64'd0);
        @(negedge clk);
        out_ready = 1'b0;

        // Back-pressure across two frames
        send_frame(32'd1, 32'd2, {1'b0, 3'b000, model_crc(32'd1, 32'd2, 3'b000)}, 8, -1, 1'b0, pv);
        check("bp first valid", {63'd0, out_valid}, 64'd1);
        check("bp overrun clear", {63'd0, overrun}, 64'd0);
        send_frame(32'd3, 32'd4, {1'b0, 3'b001, model_crc(32'd3, 32'd4, 3'b001)}, 8, -1, 1'b0, pv);
        check("bp held ab", {b, a}, {32'd2, 32'd1});
        check("bp held op_flags", {58'd0, op, err_flags}, 64'd0);
        check("bp held valid", {63'd0, out_valid}, 64'd1);
        check("bp overrun set", {63'd0, overrun}, 64'd1);
        hs0 = hs_count;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp released", {63'd0, out_valid}, 64'd0);
        repeat (3) @(negedge clk);
        check("bp one handshake", 64'(hs_count - hs0), 64'd1);

        // Reset in the middle of B[15:8]
        send_packet(1'b0, 8'h00, 1'b1);
        send_packet(1'b0, 8'h00, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        @(negedge clk);
        check("midrst out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst overrun", {63'd0, overrun}, 64'd0);
        rst = 1'b0;
        hs0 = hs_count;
        send_frame(32'hFFFF_FFFF, 32'h0, {1'b0, 3'b000, model_crc(32'hFFFF_FFFF, 32'h0, 3'b000)},
                   8, -1, 1'b0, pv);
        check("postrst valid", {63'd0, out_valid}, 64'd1);
        check("postrst err_flags", {61'd0, err_flags}, 64'd0);
        check("postrst a", {32'd0, a}, 64'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check("postrst one result", 64'(hs_count - hs0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
